// File: rtl/rvfi_bus_ser_pkg.sv
// rtl/rvfi_bus_ser_pkg.sv - configuration, batch types and helpers for the RVFI bus event serializer
package rvfi_bus_ser_pkg;

  localparam int NBUS   = 2;
  localparam int XLEN   = 32;
  localparam int BUSLEN = 32;
  localparam int MASKW  = BUSLEN / 8;
  localparam int DEPTH  = 4;
  localparam int CHW    = (NBUS > 1) ? $clog2(NBUS) : 1;
  localparam int LVW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              insn;
    logic              data;
    logic              fault;
    logic [XLEN-1:0]   addr;
    logic [MASKW-1:0]  rmask;
    logic [MASKW-1:0]  wmask;
    logic [BUSLEN-1:0] rdata;
    logic [BUSLEN-1:0] wdata;
  } bus_evt_t;

  typedef struct packed {
    logic [NBUS-1:0]           valid;
    bus_evt_t [NBUS-1:0]       evt;
  } batch_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Lowest channel index with its bit set; 0 for an empty mask.
  function automatic logic [CHW-1:0] lowest_set(input logic [NBUS-1:0] m);
    lowest_set = '0;
    for (int i = NBUS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CHW'(i);
    end
  endfunction

endpackage

// File: rtl/rvfi_bus_ser_fifo.sv
// rtl/rvfi_bus_ser_fifo.sv - batch FIFO with wrap-bit pointers, level and full/empty
module rvfi_bus_ser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rvfi_bus_event_serializer.sv
// rtl/rvfi_bus_event_serializer.sv - captures per-cycle RVFI bus event batches and replays them one per cycle
// Define RISCV_FORMAL_BUS_SER_DROPCNT_EN to add the saturating drop_cnt output.
module rvfi_bus_event_serializer
  import rvfi_bus_ser_pkg::*;
(
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NBUS-1:0]          rvfi_bus_valid,
  input  logic [NBUS-1:0]          rvfi_bus_insn,
  input  logic [NBUS-1:0]          rvfi_bus_data,
  input  logic [NBUS-1:0]          rvfi_bus_fault,
  input  logic [NBUS*XLEN-1:0]     rvfi_bus_addr,
  input  logic [NBUS*MASKW-1:0]    rvfi_bus_rmask,
  input  logic [NBUS*MASKW-1:0]    rvfi_bus_wmask,
  input  logic [NBUS*BUSLEN-1:0]   rvfi_bus_rdata,
  input  logic [NBUS*BUSLEN-1:0]   rvfi_bus_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHW-1:0]           out_chan,
  output logic                     out_last,
  output logic                     out_insn,
  output logic                     out_data,
  output logic                     out_fault,
  output logic [XLEN-1:0]          out_addr,
  output logic [MASKW-1:0]         out_rmask,
  output logic [MASKW-1:0]         out_wmask,
  output logic [BUSLEN-1:0]        out_rdata,
  output logic [BUSLEN-1:0]        out_wdata,
  output logic [LVW-1:0]           level,
`ifdef RISCV_FORMAL_BUS_SER_DROPCNT_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic                     overflow
);

  drain_state_t    state;
  drain_state_t    state_next;
  batch_t          in_batch;
  batch_t          head;
  bus_evt_t        sel;
  logic [NBUS-1:0] done_mask;
  logic [NBUS-1:0] pend;
  logic [CHW-1:0]  chan;
  logic            push;
  logic            pop;
  logic            fire;
  logic            last;
  logic            drop;
  logic            full;
  logic            empty;

  always_comb begin
    in_batch       = '0;
    in_batch.valid = rvfi_bus_valid;
    for (int c = 0; c < NBUS; c++) begin
      in_batch.evt[c].insn  = rvfi_bus_insn[c];
      in_batch.evt[c].data  = rvfi_bus_data[c];
      in_batch.evt[c].fault = rvfi_bus_fault[c];
      in_batch.evt[c].addr  = rvfi_bus_addr[c*XLEN +: XLEN];
      in_batch.evt[c].rmask = rvfi_bus_rmask[c*MASKW +: MASKW];
      in_batch.evt[c].wmask = rvfi_bus_wmask[c*MASKW +: MASKW];
      in_batch.evt[c].rdata = rvfi_bus_rdata[c*BUSLEN +: BUSLEN];
      in_batch.evt[c].wdata = rvfi_bus_wdata[c*BUSLEN +: BUSLEN];
    end
  end

  rvfi_bus_ser_fifo #(
    .WIDTH ($bits(batch_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (in_batch),
    .rdata  (head),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  // Pending events of the head are its valid bits not yet handed out; clearing
  // done_mask on the last event lets the next head start with its full mask.
  assign push = |rvfi_bus_valid;
  assign pend = head.valid & ~done_mask;
  assign chan = lowest_set(pend);
  assign last = (pend != '0) && ((pend & (pend - NBUS'(1))) == '0);
  assign sel  = head.evt[chan];
  assign fire = out_valid && out_ready;
  assign pop  = fire && last;
  assign drop = push && full && !pop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = DRAIN;
      DRAIN:   if (pop && !push && level == LVW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DRAIN);
    out_chan  = '0;
    out_last  = 1'b0;
    out_insn  = 1'b0;
    out_data  = 1'b0;
    out_fault = 1'b0;
    out_addr  = '0;
    out_rmask = '0;
    out_wmask = '0;
    out_rdata = '0;
    out_wdata = '0;
    if (state == DRAIN) begin
      out_chan  = chan;
      out_last  = last;
      out_insn  = sel.insn;
      out_data  = sel.data;
      out_fault = sel.fault;
      out_addr  = sel.addr;
      out_rmask = sel.rmask;
      out_wmask = sel.wmask;
      out_rdata = sel.rdata;
      out_wdata = sel.wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      done_mask <= '0;
      overflow  <= 1'b0;
    end else begin
      if (fire) done_mask <= last ? '0 : (done_mask | (NBUS'(1) << chan));
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef RISCV_FORMAL_BUS_SER_DROPCNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rvfi_bus_event_serializer.sv
// tb/tb_rvfi_bus_event_serializer.sv - scoreboard bench for rvfi_bus_event_serializer
module tb_rvfi_bus_event_serializer;
  import rvfi_bus_ser_pkg::*;

  logic                   clock = 1'b0;
  logic                   resetn = 1'b0;
  logic [NBUS-1:0]        rvfi_bus_valid = '0;
  logic [NBUS-1:0]        rvfi_bus_insn = '0;
  logic [NBUS-1:0]        rvfi_bus_data = '0;
  logic [NBUS-1:0]        rvfi_bus_fault = '0;
  logic [NBUS*XLEN-1:0]   rvfi_bus_addr = '0;
  logic [NBUS*MASKW-1:0]  rvfi_bus_rmask = '0;
  logic [NBUS*MASKW-1:0]  rvfi_bus_wmask = '0;
  logic [NBUS*BUSLEN-1:0] rvfi_bus_rdata = '0;
  logic [NBUS*BUSLEN-1:0] rvfi_bus_wdata = '0;
  logic                   out_ready = 1'b0;
  logic                   out_valid;
  logic [CHW-1:0]         out_chan;
  logic                   out_last;
  logic                   out_insn;
  logic                   out_data;
  logic                   out_fault;
  logic [XLEN-1:0]        out_addr;
  logic [MASKW-1:0]       out_rmask;
  logic [MASKW-1:0]       out_wmask;
  logic [BUSLEN-1:0]      out_rdata;
  logic [BUSLEN-1:0]      out_wdata;
  logic [LVW-1:0]         level;
  logic                   overflow;
`ifdef RISCV_FORMAL_BUS_SER_DROPCNT_EN
  logic [15:0]            drop_cnt;
`endif

  always #5 clock = ~clock;

  rvfi_bus_event_serializer dut (
    .clock          (clock),
    .resetn         (resetn),
    .rvfi_bus_valid (rvfi_bus_valid),
    .rvfi_bus_insn  (rvfi_bus_insn),
    .rvfi_bus_data  (rvfi_bus_data),
    .rvfi_bus_fault (rvfi_bus_fault),
    .rvfi_bus_addr  (rvfi_bus_addr),
    .rvfi_bus_rmask (rvfi_bus_rmask),
    .rvfi_bus_wmask (rvfi_bus_wmask),
    .rvfi_bus_rdata (rvfi_bus_rdata),
    .rvfi_bus_wdata (rvfi_bus_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_chan       (out_chan),
    .out_last       (out_last),
    .out_insn       (out_insn),
    .out_data       (out_data),
    .out_fault      (out_fault),
    .out_addr       (out_addr),
    .out_rmask      (out_rmask),
    .out_wmask      (out_wmask),
    .out_rdata      (out_rdata),
    .out_wdata      (out_wdata),
    .level          (level),
`ifdef RISCV_FORMAL_BUS_SER_DROPCNT_EN
    .drop_cnt       (drop_cnt),
`endif
    .overflow       (overflow)
  );

  typedef struct {
    int                chan;
    bit                last;
    logic              insn;
    logic              data;
    logic              fault;
    logic [XLEN-1:0]   addr;
    logic [MASKW-1:0]  rmask;
    logic [MASKW-1:0]  wmask;
    logic [BUSLEN-1:0] rdata;
    logic [BUSLEN-1:0] wdata;
  } ev_t;

  ev_t exp_q[$];
  int  batch_rem[$];
  bit  exp_ovf = 0;
  int  exp_drops = 0;
  int  total = 0;
  int  bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic rand_payload();
    for (int c = 0; c < NBUS; c++) begin
      rvfi_bus_addr[c*XLEN +: XLEN]     = XLEN'($urandom);
      rvfi_bus_rdata[c*BUSLEN +: BUSLEN] = BUSLEN'($urandom);
      rvfi_bus_wdata[c*BUSLEN +: BUSLEN] = BUSLEN'($urandom);
      rvfi_bus_rmask[c*MASKW +: MASKW]   = MASKW'($urandom);
      rvfi_bus_wmask[c*MASKW +: MASKW]   = MASKW'($urandom);
    end
    rvfi_bus_insn  = NBUS'($urandom);
    rvfi_bus_data  = NBUS'($urandom);
    rvfi_bus_fault = NBUS'($urandom);
  endtask

  // Reference: a list of stored batches (events remaining in each) plus the
  // flat stream of events still to appear, in arrival then channel order.
  task automatic model_edge();
    bit   popped = 0;
    ev_t  tmp[$];
    ev_t  e;
    if (batch_rem.size() > 0 && out_ready) begin
      batch_rem[0] = batch_rem[0] - 1;
      if (batch_rem[0] == 0) begin
        void'(batch_rem.pop_front());
        popped = 1;
      end
    end
    if (rvfi_bus_valid != '0) begin
      if (batch_rem.size() < DEPTH || popped) begin
        for (int c = 0; c < NBUS; c++) begin
          if (rvfi_bus_valid[c]) begin
            e.chan  = c;
            e.last  = 0;
            e.insn  = rvfi_bus_insn[c];
            e.data  = rvfi_bus_data[c];
            e.fault = rvfi_bus_fault[c];
            e.addr  = rvfi_bus_addr[c*XLEN +: XLEN];
            e.rmask = rvfi_bus_rmask[c*MASKW +: MASKW];
            e.wmask = rvfi_bus_wmask[c*MASKW +: MASKW];
            e.rdata = rvfi_bus_rdata[c*BUSLEN +: BUSLEN];
            e.wdata = rvfi_bus_wdata[c*BUSLEN +: BUSLEN];
            tmp.push_back(e);
          end
        end
        tmp[tmp.size()-1].last = 1;
        foreach (tmp[i]) exp_q.push_back(tmp[i]);
        batch_rem.push_back(tmp.size());
      end else begin
        exp_ovf = 1;
        if (exp_drops < 65535) exp_drops++;
      end
    end
  endtask

  task automatic step(input logic [NBUS-1:0] vm, input logic rdy);
    rvfi_bus_valid = vm;
    out_ready      = rdy;
    @(posedge clock);
    model_edge();
    #2;
    rand_payload();
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      check("level", 64'(level), 64'(batch_rem.size()));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
`ifdef RISCV_FORMAL_BUS_SER_DROPCNT_EN
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif
      if (out_valid && exp_q.size() != 0) begin
        check("out_chan", 64'(out_chan), 64'(exp_q[0].chan));
        check("out_last", 64'(out_last), 64'(exp_q[0].last));
        check("out_flags", 64'({out_insn, out_data, out_fault}),
              64'({exp_q[0].insn, exp_q[0].data, exp_q[0].fault}));
        check("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
        check("out_masks", 64'({out_rmask, out_wmask}), 64'({exp_q[0].rmask, exp_q[0].wmask}));
        check("out_rdata", 64'(out_rdata), 64'(exp_q[0].rdata));
        check("out_wdata", 64'(out_wdata), 64'(exp_q[0].wdata));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || batch_rem.size() != 0); i++) step('0, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rand_payload();
    repeat (2) @(posedge clock);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_payload", 64'(out_addr ^ out_rdata ^ out_wdata), 64'd0);
    resetn = 1'b1;

    // Two-channel batch replayed in channel order.
    rvfi_bus_addr = {32'h0000_0200, 32'h0000_0100};
    step(2'b11, 1'b1);
    check("t1_chan0", 64'(out_chan), 64'd0);
    check("t1_addr0", 64'(out_addr), 64'h100);
    check("t1_last0", 64'(out_last), 64'd0);
    step('0, 1'b1);
    check("t1_chan1", 64'(out_chan), 64'd1);
    check("t1_addr1", 64'(out_addr), 64'h200);
    check("t1_last1", 64'(out_last), 64'd1);
    step('0, 1'b1);

    // Backpressure holds a single event.
    step(2'b01, 1'b0);
    repeat (3) begin
      step('0, 1'b0);
      check("t2_level", 64'(level), 64'd1);
    end
    step('0, 1'b1);
    check("t2_level_after", 64'(level), 64'd0);

    // Overflow: five batches into a four-deep FIFO.
    repeat (5) step(2'b11, 1'b0);
    check("t3_level", 64'(level), 64'(DEPTH));
    check("t3_overflow", 64'(overflow), 64'd1);
`ifdef RISCV_FORMAL_BUS_SER_DROPCNT_EN
    check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Asynchronous reset in the middle of a two-event batch.
    step('0, 1'b1);
    rvfi_bus_valid = '0;
    #1 resetn = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_level", 64'(level), 64'd0);
    check("t5_overflow", 64'(overflow), 64'd0);
    exp_q.delete();
    batch_rem.delete();
    exp_ovf = 0;
    exp_drops = 0;
    @(posedge clock);
    #2 resetn = 1'b1;

    // Full FIFO with the head leaving as a new batch arrives.
    repeat (DEPTH) step(2'b01, 1'b0);
    check("t4_full_level", 64'(level), 64'(DEPTH));
    step(2'b01, 1'b1);
    check("t4_level", 64'(level), 64'(DEPTH));
    check("t4_overflow", 64'(overflow), 64'd0);
    drain(40);

    // Single faulting event on channel 1.
    rvfi_bus_fault = 2'b10;
    rvfi_bus_addr[XLEN +: XLEN] = 32'h80;
    step(2'b10, 1'b1);
    check("t6_chan", 64'(out_chan), 64'd1);
    check("t6_fault", 64'(out_fault), 64'd1);
    check("t6_last", 64'(out_last), 64'd1);
    check("t6_addr", 64'(out_addr), 64'h80);
    step('0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic [NBUS-1:0] vm;
      vm = ($urandom_range(0, 3) == 0) ? '0 : NBUS'($urandom);
      step(vm, ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
